axi4_lite_slave_regfile: RTL and testbench
==========================================

# axi4_lite_slave_regfile

AXI4-Lite slave register file that terminates the bus driven by `axi4_lite_master` and consumes its write and read bursts of incrementing word addresses. It stores `DEPTH` words, returns an OKAY or DECERR response per transfer, and keeps a saturating count of decode errors. The write and read channels run independently. Each channel accepts one transfer and then holds until its response has been handed off.

## Interface
- `ADDRESS_WIDTH`, 32: width of awaddr/araddr; addresses are word indices.
- `REG_DATA_WIDTH`, 32: width of wdata/rdata and each storage word.
- `DEPTH`, 32: number of words; valid indices are 0..DEPTH-1.
- `axi4_lite_aclk`  in  1  the single clock; all logic is rising-edge.
- `axi4_lite_aresetn`  in  1  reset, asynchronous and active-low.
- `axi4_lite_awaddr`  in  ADDRESS_WIDTH  write word index.
- `axi4_lite_awvalid`  in  1  write address valid.
- `axi4_lite_awready`  out  1  write address ready.
- `axi4_lite_wdata`  in  REG_DATA_WIDTH  write data.
- `axi4_lite_wvalid`  in  1  write data valid.
- `axi4_lite_wready`  out  1  write data ready.
- `axi4_lite_wstrb`  in  REG_DATA_WIDTH/8  byte enables; this port exists only with `AXI4_LITE_SLAVE_WSTRB_EN`.
- `axi4_lite_bresp`  out  2  write response: 2'b00 OKAY, 2'b11 DECERR.
- `axi4_lite_bvalid`  out  1  write response valid.
- `axi4_lite_bready`  in  1  write response ready.
- `axi4_lite_araddr`  in  ADDRESS_WIDTH  read word index.
- `axi4_lite_arvalid`  in  1  read address valid.
- `axi4_lite_arready`  out  1  read address ready.
- `axi4_lite_rdata`  out  REG_DATA_WIDTH  read data.
- `axi4_lite_rresp`  out  2  read response: 2'b00 OKAY, 2'b11 DECERR.
- `axi4_lite_rvalid`  out  1  read data valid.
- `axi4_lite_rready`  in  1  read data ready.
- `err_count`  out  8  saturating count of DECERR responses from both channels.

## Operation
- **Write FSM states:** W_IDLE and W_RESP.
  - awready and wready are both 1 only in W_IDLE; they are decoded from the state register.
  - Write handshake condition: W_IDLE with awvalid and wvalid both high. Address and data must arrive in the same cycle; a lone awvalid or lone wvalid is not accepted.
  - On the handshake:
    - If awaddr < DEPTH, mem[awaddr] is written and bresp becomes 2'b00.
    - Otherwise memory is unchanged and bresp becomes 2'b11.
    - bvalid becomes 1 and the FSM moves to W_RESP.
  - W_RESP: when bvalid and bready are both high, bvalid becomes 0 and the FSM returns to W_IDLE.
  - bresp holds its last value until the next write handshake.
- **Read FSM states:** R_IDLE and R_RESP.
  - arready is 1 only in R_IDLE.
  - On an arvalid handshake:
    - If araddr < DEPTH, rdata becomes mem[araddr] and rresp becomes 2'b00.
    - Otherwise rdata becomes 0 and rresp becomes 2'b11.
    - rvalid becomes 1 and the FSM moves to R_RESP.
  - R_RESP: when rvalid and rready are both high, rvalid becomes 0 and the FSM returns to R_IDLE.
  - rdata and rresp hold their values until the next read handshake.
- **Address compare:** the full ADDRESS_WIDTH bits are compared against DEPTH, with no truncation. Upper address bits being nonzero gives DECERR.
- **err_count:** increments by 1 for each DECERR handshake, and by 2 when both channels DECERR in the same cycle. It saturates at 255.
- **Same-cycle write and read to the same valid address:** the read returns the pre-write value; the write commits at that same edge.
- **Reset asserted, including mid-transfer:**
  - Any pending response is discarded.
  - Both FSMs go to IDLE and all memory words go to 0.
  - Outputs go to: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, err_count=0.
  - The ready outputs take IDLE values immediately, since reset is asynchronous.

## Timing
- Write handshake at edge N gives bvalid=1 from cycle N+1. A write whose response is accepted at N+1 allows the next write handshake at N+2, so the peak rate is one write per 2 cycles.
- Read handshake at edge N gives rvalid, rdata and rresp valid from cycle N+1; the peak rate is one read per 2 cycles.
- A response held with bready=0 or rready=0 stalls only its own channel.
- Every output except the readies is registered. The readies are decoded from the state register only and have no input-to-output combinational path.

## Configuration
- Macro `AXI4_LITE_SLAVE_WSTRB_EN`.
  - **Defined:** the `axi4_lite_wstrb` port exists. On an OKAY write, byte k of mem[awaddr] updates only when wstrb[k]=1.
  - **Undefined:** there is no wstrb port and every OKAY write replaces the full word.
  - Responses, timing and err_count are identical in both builds.

## Test plan
- **Write then read back:** write 0xDEADBEEF to index 3 with bready=1, then read index 3 → bresp=00 at cycle N+1; rdata=0xDEADBEEF, rresp=00.
- **Out-of-range write:** write to index DEPTH (32) → bresp=11, memory unchanged, err_count=1. Then read index 32 → rresp=11, rdata=0, err_count=2.
- **Backpressure:** write with bready=0 for 5 cycles → bvalid stays 1, awready stays 0, and a second awvalid/wvalid pair is not accepted until bready=1.
- **Burst of incrementing addresses:** write indices 0..7 with data 0x10..0x17, then read them all back → all OKAY, data matches, err_count=0.
- **Reset mid-transfer:** assert aresetn=0 while rvalid=1 → rvalid=0 and arready=1 immediately. After release, reading index 3 returns 0.
- **Strobe build (`AXI4_LITE_SLAVE_WSTRB_EN`):** write 0xFFFFFFFF over 0x00000000 with wstrb=4'b0101 → read returns 0x00FF00FF.

Source files
------------

// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave register file with DECERR counting
// Byte strobes are enabled by defining AXI4_LITE_SLAVE_WSTRB_EN.
module axi4_lite_slave_regfile #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int REG_DATA_WIDTH = 32,
   parameter int DEPTH          = 32
) (
   input  logic                        axi4_lite_aclk,
   input  logic                        axi4_lite_aresetn,
   input  logic [ADDRESS_WIDTH-1:0]    axi4_lite_awaddr,
   input  logic                        axi4_lite_awvalid,
   output logic                        axi4_lite_awready,
   input  logic [REG_DATA_WIDTH-1:0]   axi4_lite_wdata,
   input  logic                        axi4_lite_wvalid,
   output logic                        axi4_lite_wready,
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
   input  logic [REG_DATA_WIDTH/8-1:0] axi4_lite_wstrb,
`endif
   output logic [1:0]                  axi4_lite_bresp,
   output logic                        axi4_lite_bvalid,
   input  logic                        axi4_lite_bready,
   input  logic [ADDRESS_WIDTH-1:0]    axi4_lite_araddr,
   input  logic                        axi4_lite_arvalid,
   output logic                        axi4_lite_arready,
   output logic [REG_DATA_WIDTH-1:0]   axi4_lite_rdata,
   output logic [1:0]                  axi4_lite_rresp,
   output logic                        axi4_lite_rvalid,
   input  logic                        axi4_lite_rready,
   output logic [7:0]                  err_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH+1)'(DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t                  w_state_q, w_state_d;
   r_state_t                  r_state_q, r_state_d;
   logic [REG_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [REG_DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [1:0]                bresp_q, bresp_d;
   logic                      bvalid_q, bvalid_d;
   logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;
   logic                      rvalid_q, rvalid_d;
   logic [7:0]                err_count_q, err_count_d;

   logic                      wr_fire, rd_fire, aw_ok, ar_ok;
   logic [IDX_W-1:0]          aw_idx, ar_idx;
   logic [REG_DATA_WIDTH-1:0] wr_word;
   logic [1:0]                err_inc;
   logic [8:0]                err_sum;

   // Full-width compare so nonzero upper address bits always decode as DECERR
   assign aw_ok   = {1'b0, axi4_lite_awaddr} < DEPTH_EXT;
   assign ar_ok   = {1'b0, axi4_lite_araddr} < DEPTH_EXT;
   assign aw_idx  = axi4_lite_awaddr[IDX_W-1:0];
   assign ar_idx  = axi4_lite_araddr[IDX_W-1:0];
   assign wr_fire = (w_state_q == W_IDLE) && axi4_lite_awvalid && axi4_lite_wvalid;
   assign rd_fire = (r_state_q == R_IDLE) && axi4_lite_arvalid;

   always_comb begin
      wr_word = axi4_lite_wdata;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      for (int k = 0; k < REG_DATA_WIDTH/8; k++) begin
         if (!axi4_lite_wstrb[k]) begin
            wr_word[8*k +: 8] = mem_q[aw_idx][8*k +: 8];
         end
      end
`endif
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_fire && aw_ok) begin
         mem_d[aw_idx] = wr_word;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (wr_fire) begin
               bvalid_d  = 1'b1;
               bresp_d   = aw_ok ? RESP_OKAY : RESP_DECERR;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (axi4_lite_bready) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Reads sample mem_q, so a same-edge write to the same word is not visible yet
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_fire) begin
               rvalid_d  = 1'b1;
               rdata_d   = ar_ok ? mem_q[ar_idx] : '0;
               rresp_d   = ar_ok ? RESP_OKAY : RESP_DECERR;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (axi4_lite_rready) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      err_inc     = {1'b0, wr_fire && !aw_ok} + {1'b0, rd_fire && !ar_ok};
      err_sum     = {1'b0, err_count_q} + {7'b0, err_inc};
      err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
      if (!axi4_lite_aresetn) begin
         w_state_q   <= W_IDLE;
         r_state_q   <= R_IDLE;
         bresp_q     <= '0;
         bvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         rvalid_q    <= 1'b0;
         err_count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         bresp_q     <= bresp_d;
         bvalid_q    <= bvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         rvalid_q    <= rvalid_d;
         err_count_q <= err_count_d;
         mem_q       <= mem_d;
      end
   end

   assign axi4_lite_awready = (w_state_q == W_IDLE);
   assign axi4_lite_wready  = (w_state_q == W_IDLE);
   assign axi4_lite_arready = (r_state_q == R_IDLE);
   assign axi4_lite_bresp   = bresp_q;
   assign axi4_lite_bvalid  = bvalid_q;
   assign axi4_lite_rdata   = rdata_q;
   assign axi4_lite_rresp   = rresp_q;
   assign axi4_lite_rvalid  = rvalid_q;
   assign err_count         = err_count_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - scoreboard bench for axi4_lite_slave_regfile
// Expected responses are queued when a transfer is driven and popped when the slave responds.
module tb_axi4_lite_slave_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [7:0]  err_count;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
   } rexp_t;

   logic [1:0]  exp_b[$];
   rexp_t       exp_r[$];
   logic [31:0] mm [32];
   int          err_model;
   int          n_checks = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   axi4_lite_slave_regfile dut (
      .axi4_lite_aclk    (clk),
      .axi4_lite_aresetn (rst_n),
      .axi4_lite_awaddr  (awaddr),
      .axi4_lite_awvalid (awvalid),
      .axi4_lite_awready (awready),
      .axi4_lite_wdata   (wdata),
      .axi4_lite_wvalid  (wvalid),
      .axi4_lite_wready  (wready),
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      .axi4_lite_wstrb   (wstrb),
`endif
      .axi4_lite_bresp   (bresp),
      .axi4_lite_bvalid  (bvalid),
      .axi4_lite_bready  (bready),
      .axi4_lite_araddr  (araddr),
      .axi4_lite_arvalid (arvalid),
      .axi4_lite_arready (arready),
      .axi4_lite_rdata   (rdata),
      .axi4_lite_rresp   (rresp),
      .axi4_lite_rvalid  (rvalid),
      .axi4_lite_rready  (rready),
      .err_count         (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic err_add();
      if (err_model < 255) err_model++;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      if (a < 32) begin
         m = d;
`ifdef AXI4_LITE_SLAVE_WSTRB_EN
         for (int k = 0; k < 4; k++) if (!s[k]) m[8*k +: 8] = mm[a[4:0]][8*k +: 8];
`else
         if (s == 4'hX) m = d;
`endif
         mm[a[4:0]] = m;
         exp_b.push_back(2'b00);
      end else begin
         exp_b.push_back(2'b11);
         err_add();
      end
   endtask

   task automatic model_read(input logic [31:0] a);
      rexp_t e;
      if (a < 32) begin
         e.d = mm[a[4:0]];
         e.r = 2'b00;
      end else begin
         e.d = 32'h0;
         e.r = 2'b11;
         err_add();
      end
      exp_r.push_back(e);
   endtask

   task automatic wr_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
   endtask

   task automatic wr_finish();
      int n = 0;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      chk("aw_accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid_latency", 32'(bvalid), 32'd1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      model_write(a, d, s);
      wr_start(a, d, s);
      wr_finish();
   endtask

   task automatic rd_start(input logic [31:0] a);
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
   endtask

   task automatic rd_finish();
      int n = 0;
      while (!arready && n < 50) begin @(negedge clk); n++; end
      chk("ar_accept_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rvalid_latency", 32'(rvalid), 32'd1);
   endtask

   task automatic rd(input logic [31:0] a);
      model_read(a);
      rd_start(a);
      rd_finish();
   endtask

   task automatic get_b(input string tag);
      int n = 0;
      logic [1:0] e;
      @(negedge clk);
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      chk("bvalid_timeout", 32'(n < 50), 32'd1);
      if (exp_b.size() == 0) begin
         chk("b_scoreboard_empty", 32'(exp_b.size()), 32'd1);
      end else begin
         e = exp_b.pop_front();
         chk(tag, 32'(bresp), 32'(e));
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   task automatic get_r(input string tag);
      int n = 0;
      rexp_t e;
      @(negedge clk);
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      chk("rvalid_timeout", 32'(n < 50), 32'd1);
      if (exp_r.size() == 0) begin
         chk("r_scoreboard_empty", 32'(exp_r.size()), 32'd1);
      end else begin
         e = exp_r.pop_front();
         chk({tag, "_rdata"}, rdata, e.d);
         chk({tag, "_rresp"}, 32'(rresp), 32'(e.r));
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      chk("rvalid_clear", 32'(rvalid), 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mm[i] = 32'h0;
      err_model = 0;
      exp_b.delete();
      exp_r.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      awaddr = '0; wdata = '0; wstrb = 4'hF; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_awready", 32'(awready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_bresp", 32'(bresp), 32'd0);
      chk("rst_rresp", 32'(rresp), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);

      // write then read back
      wr(32'd3, 32'hDEADBEEF, 4'hF); get_b("wr3_bresp");
      rd(32'd3);                     get_r("rd3");

      // out-of-range writes and reads
      wr(32'd32, 32'h12345678, 4'hF); get_b("wr32_bresp");
      chk("err_after_wr32", 32'(err_count), 32'(err_model));
      rd(32'd32);                     get_r("rd32");
      chk("err_after_rd32", 32'(err_count), 32'(err_model));
      wr(32'h8000_0003, 32'hBAD0BAD0, 4'hF); get_b("wr_hi_bresp");
      rd(32'd3);                             get_r("rd3_unchanged");
      rd(32'h8000_0003);                     get_r("rd_hi");

      // write response backpressure stalls only the write channel
      wr(32'd5, 32'h5555_0005, 4'hF);
      model_write(32'd6, 32'h6666_0006, 4'hF);
      wr_start(32'd6, 32'h6666_0006, 4'hF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_bvalid", 32'(bvalid), 32'd1);
         chk("bp_awready", 32'(awready), 32'd0);
      end
      rd(32'd3); get_r("rd_during_bp");
      get_b("bp_first_bresp");
      wr_finish();
      get_b("bp_second_bresp");
      rd(32'd5); get_r("rd5");
      rd(32'd6); get_r("rd6");

      // burst of incrementing addresses
      for (int i = 0; i < 8; i++) begin
         wr(32'(i), 32'h10 + 32'(i), 4'hF); get_b("burst_bresp");
      end
      for (int i = 0; i < 8; i++) begin
         rd(32'(i)); get_r("burst_rd");
      end
      chk("burst_err_count", 32'(err_count), 32'(err_model));

      // same-cycle write and read of one word returns the old value
      model_read(32'd2);
      model_write(32'd2, 32'hAAAA_5555, 4'hF);
      @(negedge clk);
      awaddr = 32'd2; wdata = 32'hAAAA_5555; wstrb = 4'hF; araddr = 32'd2;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      get_b("same_cycle_bresp");
      get_r("same_cycle_rd");
      rd(32'd2); get_r("same_cycle_after");

      // simultaneous DECERRs count twice and saturate at 255
      for (int i = 0; i < 130; i++) begin
         model_write(32'd40, 32'h0, 4'hF);
         model_read(32'd50);
         @(negedge clk);
         awaddr = 32'd40; araddr = 32'd50;
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         @(posedge clk); #1;
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         if (i == 0) chk("double_err", 32'(err_count), 32'(err_model));
         get_b("dual_err_bresp");
         get_r("dual_err_rd");
      end
      chk("err_saturated", 32'(err_count), 32'd255);

      // reset while a read response is pending
      rd_start(32'd3);
      rd_finish();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_arready", 32'(arready), 32'd1);
      chk("midrst_awready", 32'(awready), 32'd1);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_err_count", 32'(err_count), 32'd0);
      rready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd(32'd3); get_r("rd3_after_reset");

`ifdef AXI4_LITE_SLAVE_WSTRB_EN
      wr(32'd9, 32'h0000_0000, 4'hF);  get_b("strb_clear_bresp");
      wr(32'd9, 32'hFFFF_FFFF, 4'h5);  get_b("strb_bresp");
      rd(32'd9);                       get_r("strb_rd");
      chk("strb_model_value", mm[9], 32'h00FF_00FF);
`endif

      chk("final_err_count", 32'(err_count), 32'(err_model));
      chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
      chk("r_queue_drained", 32'(exp_r.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
